// File: rtl/encoder_defs.sv
// Shared constants and helpers for the four-to-two NAND encoder slice.
package encoder_defs;

   localparam int NUM_LINES = 4;
   localparam int CODE_W    = 2;
   localparam logic [NUM_LINES-1:0] LINES_IDLE = 4'b1111;

   // Index of the lowest set bit; line 0 has the highest priority.
   function automatic logic [CODE_W-1:0] lowest_index(input logic [NUM_LINES-1:0] bits);
      logic [CODE_W-1:0] idx;
      idx = '0;
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if (bits[i]) idx = CODE_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/four_to_two_nand_encoder_if.sv
// Consumer-side valid/ready handshake carrying the encoded line index.
interface four_to_two_nand_encoder_if;
   import encoder_defs::*;

   logic [CODE_W-1:0] code;
   logic              valid;
   logic              ready;

   modport master (output code, output valid, input ready);
   modport slave  (input code, input valid, output ready);

endinterface

// File: rtl/sync_fifo.sv
// Small power-of-two FIFO with occupancy count; the caller guarantees no push when full without a pop.
module sync_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 2,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [PTR_W:0]   level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + (PTR_W+1)'(1);
            2'b01:   level <= level - (PTR_W+1)'(1);
            default: level <= level;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; level gates every read, so stale entries are never visible.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/four_to_two_nand_encoder.sv
// Encodes falling edges on four active-low select lines into queued 2-bit codes.
// Optional macro FOUR_TO_TWO_SYNC_IN_EN adds a 2-flop input synchronizer (latency 2 -> 4 cycles).
module four_to_two_nand_encoder
   import encoder_defs::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_LINES-1:0]    d_n,
   four_to_two_nand_encoder_if.master bus,
   output logic                    overflow,
   output logic [PTR_W:0]          level
);

   localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

   logic [NUM_LINES-1:0] d_in;
   logic [NUM_LINES-1:0] d_n_q;
   logic [NUM_LINES-1:0] fall;
   logic [NUM_LINES-1:0] pending;
   logic [NUM_LINES-1:0] grant;
   logic [CODE_W-1:0]    grant_idx;
   logic [CODE_W-1:0]    head;
   logic                 pop;
   logic                 push;

`ifdef FOUR_TO_TWO_SYNC_IN_EN
   logic [NUM_LINES-1:0] sync_q1;
   logic [NUM_LINES-1:0] sync_q2;

   // Both stages reset to idle so a released reset never fakes an edge mid-synchronizer.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= LINES_IDLE;
         sync_q2 <= LINES_IDLE;
      end else begin
         sync_q1 <= d_n;
         sync_q2 <= sync_q1;
      end
   end

   assign d_in = sync_q2;
`else
   assign d_in = d_n;
`endif

   assign fall      = d_n_q & ~d_in;
   assign pop       = bus.valid & bus.ready;
   assign push      = (pending != '0) && ((level != FULL_LEVEL) || pop);
   assign grant_idx = lowest_index(pending);
   assign grant     = push ? (NUM_LINES'(1) << grant_idx) : '0;

   // A new fall on a bit being granted this cycle re-arms it rather than counting as a drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_n_q    <= LINES_IDLE;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         d_n_q   <= d_in;
         pending <= (pending & ~grant) | fall;
         if ((fall & pending & ~grant) != '0) overflow <= 1'b1;
      end
   end

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CODE_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (grant_idx),
      .pop       (pop),
      .head      (head),
      .level     (level)
   );

   assign bus.valid = (level != '0);
   assign bus.code  = bus.valid ? head : '0;

endmodule

// File: tb/tb_four_to_two_nand_encoder.sv
// Scoreboard bench: expected codes are queued as edges are driven and matched on each handshake.
module tb_four_to_two_nand_encoder;

   logic       clk;
   logic       rst;
   logic [3:0] d_n;
   logic       overflow;
   logic [2:0] level;

   four_to_two_nand_encoder_if bus_if ();

   four_to_two_nand_encoder #(.DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .d_n      (d_n),
      .bus      (bus_if),
      .overflow (overflow),
      .level    (level)
   );

   int         n_compared   = 0;
   int         n_mismatched = 0;
   logic [1:0] sb [$];
   logic [1:0] exp_code;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Handshake monitor: every accepted code must match the oldest expected one.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus_if.valid === 1'b1 && bus_if.ready === 1'b1) begin
         n_compared++;
         if (sb.size() == 0) begin
            n_mismatched++;
            $display("FAIL pop_unexpected: got code %0d, expected no delivery", bus_if.code);
         end else begin
            exp_code = sb.pop_front();
            if (bus_if.code !== exp_code) begin
               n_mismatched++;
               $display("FAIL pop_code: got %0d, expected %0d", bus_if.code, exp_code);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) next_cycle();
   endtask

   task automatic pulse(input logic [3:0] lines);
      d_n = lines;
      next_cycle();
      d_n = 4'b1111;
   endtask

   task automatic fill_all();
      bus_if.ready = 1'b0;
      for (int i = 0; i < 4; i++) sb.push_back(2'(i));
      pulse(4'b0000);
      wait_cycles(6);
   endtask

   task automatic drain(input int n);
      bus_if.ready = 1'b1;
      wait_cycles(n);
      bus_if.ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      d_n = 4'b1111;
      bus_if.ready = 1'b0;
      wait_cycles(2);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         n_compared++;
         if ({bus_if.valid, level, overflow} !== 5'b0) begin
            n_mismatched++;
            $display("FAIL reset_idle[%0d]: got valid=%b level=%0d overflow=%b, expected 0/0/0",
                     i, bus_if.valid, level, overflow);
         end
      end
   endtask

   task automatic test_single_pulse();
      bus_if.ready = 1'b1;
      sb.push_back(2'd2);
      pulse(4'b1011);
      n_compared++;
      if (bus_if.valid !== 1'b0) begin
         n_mismatched++;
         $display("FAIL single_early: got valid=%b, expected 0", bus_if.valid);
      end
      next_cycle();
      n_compared++;
      if (bus_if.valid !== 1'b1 || bus_if.code !== 2'd2) begin
         n_mismatched++;
         $display("FAIL single_valid: got valid=%b code=%0d, expected 1/2", bus_if.valid, bus_if.code);
      end
      next_cycle();
      n_compared++;
      if (bus_if.valid !== 1'b0 || level !== 3'd0) begin
         n_mismatched++;
         $display("FAIL single_once: got valid=%b level=%0d, expected 0/0", bus_if.valid, level);
      end
      bus_if.ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      bus_if.ready = 1'b0;
      for (int i = 0; i < 4; i++) sb.push_back(2'(i));
      d_n = 4'b0000;
      wait_cycles(2);
      n_compared++;
      if (bus_if.valid !== 1'b1 || bus_if.code !== 2'd0 || level !== 3'd1) begin
         n_mismatched++;
         $display("FAIL simul_first: got valid=%b code=%0d level=%0d, expected 1/0/1",
                  bus_if.valid, bus_if.code, level);
      end
      wait_cycles(6);
      n_compared++;
      if (level !== 3'd4 || bus_if.code !== 2'd0) begin
         n_mismatched++;
         $display("FAIL simul_full: got level=%0d code=%0d, expected 4/0", level, bus_if.code);
      end
      drain(7);
      n_compared++;
      if (level !== 3'd0 || sb.size() != 0) begin
         n_mismatched++;
         $display("FAIL simul_no_repeat: got level=%0d left=%0d, expected 0/0", level, sb.size());
      end
      d_n = 4'b1111;
      wait_cycles(3);
      n_compared++;
      if (bus_if.valid !== 1'b0) begin
         n_mismatched++;
         $display("FAIL simul_release: got valid=%b, expected 0", bus_if.valid);
      end
   endtask

   task automatic test_backpressure();
      fill_all();
      n_compared++;
      if (level !== 3'd4) begin
         n_mismatched++;
         $display("FAIL bp_fill: got level=%0d, expected 4", level);
      end
      sb.push_back(2'd1);
      pulse(4'b1101);
      wait_cycles(4);
      n_compared++;
      if (level !== 3'd4 || bus_if.code !== 2'd0) begin
         n_mismatched++;
         $display("FAIL bp_hold: got level=%0d code=%0d, expected 4/0", level, bus_if.code);
      end
      bus_if.ready = 1'b1;
      next_cycle();
      bus_if.ready = 1'b0;
      n_compared++;
      if (level !== 3'd4 || bus_if.code !== 2'd1) begin
         n_mismatched++;
         $display("FAIL bp_pop_push: got level=%0d code=%0d, expected 4/1", level, bus_if.code);
      end
      drain(6);
      n_compared++;
      if (level !== 3'd0 || sb.size() != 0) begin
         n_mismatched++;
         $display("FAIL bp_drain: got level=%0d left=%0d, expected 0/0", level, sb.size());
      end
   endtask

   task automatic test_overflow();
      fill_all();
      sb.push_back(2'd3);
      pulse(4'b0111);
      wait_cycles(2);
      n_compared++;
      if (overflow !== 1'b0) begin
         n_mismatched++;
         $display("FAIL ovf_first: got overflow=%b, expected 0", overflow);
      end
      pulse(4'b0111);
      wait_cycles(2);
      n_compared++;
      if (overflow !== 1'b1 || level !== 3'd4) begin
         n_mismatched++;
         $display("FAIL ovf_second: got overflow=%b level=%0d, expected 1/4", overflow, level);
      end
      drain(10);
      n_compared++;
      if (overflow !== 1'b1 || level !== 3'd0 || sb.size() != 0) begin
         n_mismatched++;
         $display("FAIL ovf_sticky: got overflow=%b level=%0d left=%0d, expected 1/0/0",
                  overflow, level, sb.size());
      end
   endtask

   task automatic test_reset_mid();
      bus_if.ready = 1'b0;
      for (int i = 0; i < 3; i++) sb.push_back(2'(i));
      pulse(4'b1000);
      wait_cycles(5);
      n_compared++;
      if (level !== 3'd3 || bus_if.code !== 2'd0) begin
         n_mismatched++;
         $display("FAIL mid_setup: got level=%0d code=%0d, expected 3/0", level, bus_if.code);
      end
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      sb.delete();
      n_compared++;
      if ({bus_if.valid, level, overflow, bus_if.code} !== 7'b0) begin
         n_mismatched++;
         $display("FAIL mid_reset: got valid=%b level=%0d overflow=%b code=%0d, expected all 0",
                  bus_if.valid, level, overflow, bus_if.code);
      end
      bus_if.ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         n_compared++;
         if (bus_if.valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL mid_stale[%0d]: got valid=%b, expected 0", i, bus_if.valid);
         end
      end
      bus_if.ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      d_n = 4'b1111;
      bus_if.ready = 1'b0;
      test_reset();
      test_single_pulse();
      test_simultaneous();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
